// File: rtl/tipi_nib_master.sv
// Initiator end of the TIPI nibble bus: turns single-byte register commands into r_clk/r_nibrst/r_nib frames.
// Optional parity period after the data nibbles is enabled with `define TIPI_NIB_PARITY_EN.
module tipi_nib_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       r_reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [1:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       busy,
  output logic       r_clk_o,
  output logic       r_nibrst_o,
  output logic [3:0] r_nib_o,
  output logic       r_nib_oe,
  input  logic [3:0] r_nib_i
);

  localparam int unsigned PW = $clog2(2 * CLK_DIV);
  localparam logic [PW-1:0] PH_HI   = PW'(CLK_DIV);
  localparam logic [PW-1:0] PH_LAST = PW'(2 * CLK_DIV - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RST  = 3'd1;
  localparam logic [2:0] ST_CMD  = 3'd2;
  localparam logic [2:0] ST_TURN = 3'd3;
  localparam logic [2:0] ST_D_HI = 3'd4;
  localparam logic [2:0] ST_D_LO = 3'd5;
  localparam logic [2:0] ST_PAR  = 3'd6;
  localparam logic [2:0] ST_DONE = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          write_q, write_d;
  logic [1:0]    reg_q, reg_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rbuf_q, rbuf_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          busy_q, busy_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_rdata_q, rsp_rdata_d;
  logic          r_clk_q, r_clk_d;
  logic          r_nibrst_q, r_nibrst_d;
  logic [3:0]    r_nib_q, r_nib_d;
  logic          r_nib_oe_q, r_nib_oe_d;
  logic          active;
`ifdef TIPI_NIB_PARITY_EN
  logic [3:0]    par_q, par_d;
  logic          rsp_err_q, rsp_err_d;
`endif

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (r_reset) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      write_q     <= 1'b0;
      reg_q       <= 2'd0;
      wdata_q     <= 8'h00;
      rbuf_q      <= 8'h00;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      r_clk_q     <= 1'b0;
      r_nibrst_q  <= 1'b0;
      r_nib_q     <= 4'h0;
      r_nib_oe_q  <= 1'b0;
`ifdef TIPI_NIB_PARITY_EN
      par_q       <= 4'h0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      write_q     <= write_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      r_clk_q     <= r_clk_d;
      r_nibrst_q  <= r_nibrst_d;
      r_nib_q     <= r_nib_d;
      r_nib_oe_q  <= r_nib_oe_d;
`ifdef TIPI_NIB_PARITY_EN
      par_q       <= par_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  // Next state; outputs are derived from the next state so they line up with it
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    write_d = write_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    rbuf_d  = rbuf_q;
`ifdef TIPI_NIB_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          write_d = cmd_write;
          reg_d   = cmd_reg;
          wdata_d = cmd_wdata;
          state_d = ST_RST;
          phase_d = '0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        // Responder data settles during the low phase; take it on the first high cycle
        if (phase_q == PH_HI && !write_q) begin
          case (state_q)
            ST_D_HI: rbuf_d[7:4] = r_nib_i;
            ST_D_LO: rbuf_d[3:0] = r_nib_i;
`ifdef TIPI_NIB_PARITY_EN
            ST_PAR:  par_d = r_nib_i;
`endif
            default: ;
          endcase
        end
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          case (state_q)
            ST_RST:  state_d = ST_CMD;
            ST_CMD:  state_d = write_q ? ST_D_HI : ST_TURN;
            ST_TURN: state_d = ST_D_HI;
            ST_D_HI: state_d = ST_D_LO;
`ifdef TIPI_NIB_PARITY_EN
            ST_D_LO: state_d = ST_PAR;
`else
            ST_D_LO: state_d = ST_DONE;
`endif
            default: state_d = ST_DONE;
          endcase
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
    endcase

    active      = (state_d != ST_IDLE) && (state_d != ST_DONE);
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    rsp_valid_d = (state_d == ST_DONE);
    r_clk_d     = active && (phase_d >= PH_HI);
    r_nibrst_d  = (state_d == ST_RST);

    case (state_d)
      ST_RST, ST_CMD:          r_nib_oe_d = 1'b1;
      ST_D_HI, ST_D_LO, ST_PAR: r_nib_oe_d = write_d;
      default:                 r_nib_oe_d = 1'b0;
    endcase

    r_nib_d = r_nib_q;
    if (active && phase_d == '0) begin
      case (state_d)
        ST_CMD:  r_nib_d = {write_d, 1'b0, reg_d};
        ST_D_HI: r_nib_d = write_d ? wdata_d[7:4] : 4'h0;
        ST_D_LO: r_nib_d = write_d ? wdata_d[3:0] : 4'h0;
        ST_PAR:  r_nib_d = write_d ? {3'b000, ^wdata_d} : 4'h0;
        default: r_nib_d = 4'h0;
      endcase
    end

    rsp_rdata_d = rsp_rdata_q;
    if (rsp_valid_d && !write_d) rsp_rdata_d = rbuf_d;
`ifdef TIPI_NIB_PARITY_EN
    rsp_err_d = rsp_valid_d && !write_d &&
                ((par_d[3:1] != 3'b000) || (par_d[0] != ^rbuf_d));
`endif
  end

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign r_clk_o    = r_clk_q;
  assign r_nibrst_o = r_nibrst_q;
  assign r_nib_o    = r_nib_q;
  assign r_nib_oe   = r_nib_oe_q;
`ifdef TIPI_NIB_PARITY_EN
  assign rsp_err    = rsp_err_q;
`else
  assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_tipi_nib_master.sv
// Directed bench for tipi_nib_master: two instances (CLK_DIV=2 and 1), bench responder and scoreboard.
module tb_tipi_nib_master;

`ifdef TIPI_NIB_PARITY_EN
  localparam int PAR_P = 1;
`else
  localparam int PAR_P = 0;
`endif

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         lat;
  } rsp_t;

  logic       clk = 1'b0;
  logic       r_reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_write = 1'b0;
  logic [1:0] cmd_reg = 2'd0;
  logic [7:0] cmd_wdata = 8'h00;
  logic [3:0] r_nib_i = 4'h0;
  logic       sel_b = 1'b0;

  logic       a_ready, a_valid, a_err, a_busy, a_rclk, a_nibrst, a_oe;
  logic [7:0] a_rdata;
  logic [3:0] a_nib;
  logic       b_ready, b_valid, b_err, b_busy, b_rclk, b_nibrst, b_oe;
  logic [7:0] b_rdata;
  logic [3:0] b_nib;

  logic       m_ready, m_valid, m_err, m_busy, m_rclk, m_nibrst, m_oe;
  logic [7:0] m_rdata;
  logic [3:0] m_nib;

  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  int         done_cyc = 0;
  int         rise_cnt = 0;
  logic       prev_rclk = 1'b0;
  logic       resp_rd = 1'b0;
  logic [7:0] resp_byte = 8'h00;
  logic [3:0] resp_par = 4'h0;
  logic [7:0] exp_hold = 8'h00;
  logic [3:0] nib_q[$];
  rsp_t       rsp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tipi_nib_master #(.CLK_DIV(2)) u_dut_a (
    .clk(clk), .r_reset(r_reset), .cmd_valid(cmd_valid && !sel_b), .cmd_ready(a_ready),
    .cmd_write(cmd_write), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(a_valid), .rsp_rdata(a_rdata), .rsp_err(a_err), .busy(a_busy),
    .r_clk_o(a_rclk), .r_nibrst_o(a_nibrst), .r_nib_o(a_nib), .r_nib_oe(a_oe), .r_nib_i(r_nib_i)
  );

  tipi_nib_master #(.CLK_DIV(1)) u_dut_b (
    .clk(clk), .r_reset(r_reset), .cmd_valid(cmd_valid && sel_b), .cmd_ready(b_ready),
    .cmd_write(cmd_write), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(b_valid), .rsp_rdata(b_rdata), .rsp_err(b_err), .busy(b_busy),
    .r_clk_o(b_rclk), .r_nibrst_o(b_nibrst), .r_nib_o(b_nib), .r_nib_oe(b_oe), .r_nib_i(r_nib_i)
  );

  assign m_ready  = sel_b ? b_ready  : a_ready;
  assign m_valid  = sel_b ? b_valid  : a_valid;
  assign m_rdata  = sel_b ? b_rdata  : a_rdata;
  assign m_err    = sel_b ? b_err    : a_err;
  assign m_busy   = sel_b ? b_busy   : a_busy;
  assign m_rclk   = sel_b ? b_rclk   : a_rclk;
  assign m_nibrst = sel_b ? b_nibrst : a_nibrst;
  assign m_nib    = sel_b ? b_nib    : a_nib;
  assign m_oe     = sel_b ? b_oe     : a_oe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor, responder and response scoreboard, all sampled mid-cycle
  always @(negedge clk) begin
    if (r_reset) begin
      prev_rclk = m_rclk;
    end else begin
      if (cmd_valid && m_ready) acc_cyc = cyc;
      if (m_rclk && !prev_rclk) begin
        if (m_nibrst) begin
          rise_cnt = 0;
          chk("rst_frame", {27'd0, m_oe, m_nib}, 32'h10);
        end else begin
          rise_cnt++;
          if (nib_q.size() == 0) chk("nib_unexpected_oe", 32'(m_oe), 32'd0);
          else if (!m_oe) chk("nib_oe", 32'(m_oe), 32'd1);
          else chk("nib", 32'(m_nib), 32'(nib_q.pop_front()));
        end
      end
      if (!m_rclk && prev_rclk && resp_rd) begin
        case (rise_cnt)
          2: r_nib_i = resp_byte[7:4];
          3: r_nib_i = resp_byte[3:0];
          4: r_nib_i = resp_par;
          default: ;
        endcase
      end
      prev_rclk = m_rclk;
      if (m_valid) begin
        done_cyc = cyc;
        if (rsp_q.size() == 0) chk("rsp_unexpected", 32'(m_valid), 32'd0);
        else begin
          rsp_t e;
          e = rsp_q.pop_front();
          chk("rsp_rdata", 32'(m_rdata), 32'(e.rdata));
          chk("rsp_err", 32'(m_err), 32'(e.err));
          chk("rsp_latency", 32'(cyc - acc_cyc), 32'(e.lat));
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [1:0] rg, input logic [7:0] d,
                       input logic [7:0] rb, input logic [3:0] par, input bit hold);
    rsp_t e;
    int   dv;
    dv = sel_b ? 1 : 2;
    nib_q.push_back({w, 1'b0, rg});
    if (w) begin
      nib_q.push_back(d[7:4]);
      nib_q.push_back(d[3:0]);
      if (PAR_P != 0) nib_q.push_back({3'b000, ^d});
    end
    if (!w) exp_hold = rb;
    e.rdata = exp_hold;
    e.err   = !w && (PAR_P != 0) && ((par[3:1] != 3'b000) || (par[0] != ^rb));
    e.lat   = 1 + (w ? 8 : 10) * dv + 2 * PAR_P * dv;
    rsp_q.push_back(e);
    resp_rd   = !w;
    resp_byte = rb;
    resp_par  = par;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_reg   = rg;
    cmd_wdata = d;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (m_ready) break;
    end
    chk("accept", 32'(m_ready), 32'd1);
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
    cmd_wdata = ~d;
    cmd_reg   = ~rg;
  endtask

  task automatic wait_done(output int nibrst_cyc);
    nibrst_cyc = 0;
    for (int k = 0; k < 400 && rsp_q.size() != 0; k++) begin
      @(negedge clk);
      if (m_nibrst) nibrst_cyc++;
    end
    chk("rsp_pending", 32'(rsp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int         nr;
    logic [7:0] hold_a;
    repeat (3) @(posedge clk);
    #1 r_reset = 1'b0;
    @(negedge clk);
    chk("reset_rclk", 32'(m_rclk), 32'd0);
    chk("reset_nibrst", 32'(m_nibrst), 32'd0);
    chk("reset_nib", {26'd0, m_oe, m_nib, m_valid}, 32'd0);
    chk("reset_rsp", {22'd0, m_rdata, m_err, m_busy}, 32'd0);
    chk("reset_ready", 32'(m_ready), 32'd1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("idle_rclk", 32'(m_rclk), 32'd0);
    end

    // Write RD 0x5A, then read TD 0xC3 at CLK_DIV=2
    @(posedge clk); #1;
    issue(1'b1, 2'd2, 8'h5A, 8'h00, 4'h0, 1'b0);
    wait_done(nr);
    chk("nibrst_len", 32'(nr), 32'd4);
    issue(1'b0, 2'd0, 8'h00, 8'hC3, {3'b000, ^8'hC3}, 1'b0);
    wait_done(nr);
    chk("idle_oe", 32'(m_oe), 32'd0);

    // Back-to-back with cmd_valid held, CLK_DIV=1
    hold_a   = exp_hold;
    sel_b    = 1'b1;
    exp_hold = 8'h00;
    @(posedge clk); #1;
    issue(1'b1, 2'd1, 8'hFF, 8'h00, 4'h0, 1'b1);
    @(negedge clk);
    chk("ready_while_busy", 32'(m_ready), 32'd0);
    chk("busy_while_busy", 32'(m_busy), 32'd1);
    @(posedge clk); #1;
    issue(1'b0, 2'd3, 8'h00, 8'h81, {3'b000, ^8'h81}, 1'b0);
    chk("b2b_gap", 32'(acc_cyc - done_cyc), 32'd1);
    wait_done(nr);
    chk("b2b_rdata", 32'(m_rdata), 32'h81);

    // Reset during D_HI of a read aborts silently
    sel_b    = 1'b0;
    exp_hold = hold_a;
    @(posedge clk); #1;
    issue(1'b0, 2'd0, 8'h00, 8'hC3, 4'h0, 1'b0);
    for (int k = 0; k < 200 && rise_cnt != 3; k++) begin
      @(posedge clk); #1;
    end
    chk("reached_d_hi", 32'(rise_cnt), 32'd3);
    r_reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_rclk", 32'(m_rclk), 32'd0);
    chk("abort_oe", 32'(m_oe), 32'd0);
    chk("abort_busy", 32'(m_busy), 32'd0);
    chk("abort_valid", 32'(m_valid), 32'd0);
    r_reset = 1'b0;
    rsp_q.delete();
    nib_q.delete();
    exp_hold = 8'h00;
    resp_rd  = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_idle_ready", 32'(m_ready), 32'd1);
    @(posedge clk); #1;
    issue(1'b1, 2'd0, 8'h12, 8'h00, 4'h0, 1'b0);
    wait_done(nr);

    // Parity nibble good and bad (plain reads without the feature)
    issue(1'b0, 2'd2, 8'h00, 8'h07, 4'h1, 1'b0);
    wait_done(nr);
    issue(1'b0, 2'd3, 8'h00, 8'h07, 4'h0, 1'b0);
    wait_done(nr);
    issue(1'b1, 2'd1, 8'hA5, 8'h00, 4'h0, 1'b0);
    wait_done(nr);
    chk("final_nib_q", 32'(nib_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tipi_nib_master.md
Name: tipi_nib_master

Overview:
- Initiator end of the TIPI nibble bus, the serial link the Pi side uses to reach the TIPI register file.
- Used by the FPGA Pi-replacement bring-up target and as the bus-functional master in regression benches.
- Turns single-byte register read/write commands into r_clk/r_nibrst/r_nib sequences and returns read data through a valid pulse.

Parameters:
- CLK_DIV, 4, system clocks per r_clk half-period; legal range is 1 or more.

Ports:
- clk  in  1  system clock; all logic on rising edge
- r_reset  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE only; a command is accepted when cmd_valid and cmd_ready are both high at an edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_reg  in  2  register select: 0=TD, 1=TC, 2=RD, 3=RC
- cmd_wdata  in  8  write data
- rsp_valid  out  1  one-cycle pulse at transaction end (reads and writes)
- rsp_rdata  out  8  read data; held until the next read completes
- rsp_err  out  1  parity error flag, qualified by rsp_valid
- busy  out  1  high from acceptance through the DONE cycle
- r_clk_o  out  1  nibble bus clock
- r_nibrst_o  out  1  nibble bus framing reset
- r_nib_o  out  4  nibble drive data
- r_nib_oe  out  1  nibble bus output enable
- r_nib_i  in  4  nibble bus sampled data

Behaviour:
- Reset values: r_clk_o=0, r_nibrst_o=0, r_nib_o=0, r_nib_oe=0, rsp_valid=0, rsp_rdata=0x00, rsp_err=0, busy=0, state=IDLE. cmd_ready=1 after reset.
- Reset asserted mid-transaction aborts on the next edge. No rsp_valid is generated.
- On acceptance (cycle 0), cmd_write, cmd_reg and cmd_wdata are registered. Later input changes are ignored. cmd_valid while busy is ignored.
- Nibble period = 2*CLK_DIV clocks.
  - Low phase: first CLK_DIV clocks, r_clk_o=0. r_nib_o is updated on the first cycle of the low phase.
  - High phase: next CLK_DIV clocks, r_clk_o=1.
  - The responder samples on r_clk rising and drives read data after r_clk falls.
  - The master samples r_nib_i on the first clk cycle with r_clk_o=1.
- State sequence and per-period actions:
  - RST: one period, r_nibrst_o=1, r_nib_oe=1, r_nib_o=0.
  - CMD: one period. Nibble = {cmd_write, 0, cmd_reg}.
  - Write path: D_HI drives wdata[7:4], then D_LO drives wdata[3:0]; r_nib_oe=1 throughout.
  - Read path: TURN is one period with r_nib_oe=0 and r_clk toggling. D_HI and D_LO then sample into rdata[7:4] and rdata[3:0].
  - DONE: one cycle, rsp_valid=1, r_clk_o=0, r_nib_oe=0; next state is IDLE.
  - rsp_rdata updates in DONE for reads only.
- Latency, acceptance to rsp_valid: write 1+8*CLK_DIV cycles; read 1+10*CLK_DIV cycles.
- IDLE: r_clk_o=0, r_nibrst_o=0, r_nib_oe=0.
- Back-to-back commands: the next command is accepted no earlier than the cycle after DONE.
- CLK_DIV=1 is legal: each phase lasts a single clock.

Optional Feature:
- Macro: TIPI_NIB_PARITY_EN.
- Defined: a PAR period follows D_LO. Its nibble is {3'b000, p}, where p is the even parity (XOR) of the data byte.
  - Write: the master drives the PAR nibble.
  - Read: the master samples it; rsp_err=1 in DONE if the sampled p differs from XOR(rdata) or if bits [3:1] are nonzero.
  - Latency grows by 2*CLK_DIV.
- Undefined: no PAR period; rsp_err is tied to 0.

Test Plan:
- Reset: CLK_DIV=2, r_reset high for 3 cycles then low → all outputs at reset values, cmd_ready=1, r_clk_o static 0 for 20 cycles.
- Write RD: cmd_write=1, cmd_reg=2, cmd_wdata=0x5A, CLK_DIV=2 → r_nibrst_o high for 4 cycles, nibbles A,5,A on r_clk rising edges, rsp_valid at cycle 17, rsp_rdata unchanged.
- Read TD: bench responder returns 0xC3 (C then 3 after falling edges), CLK_DIV=2 → cmd nibble 0x0, r_nib_oe=0 from the TURN period onward, rsp_valid at cycle 21, rsp_rdata=0xC3.
- Busy and back-to-back: cmd_valid held high with two commands (write TC 0xFF, read RC 0x81), CLK_DIV=1 → second accepted the cycle after the first DONE, cmd_ready=0 while busy, rsp_rdata=0x81.
- Reset mid-read: assert r_reset during D_HI → next edge r_clk_o=0, r_nib_oe=0, busy=0, no rsp_valid; a following write TD 0x12 completes normally.
- With TIPI_NIB_PARITY_EN: read returns 0x07 with PAR nibble 0x1 → rsp_err=0; PAR nibble 0x0 → rsp_err=1, latency 1+12*CLK_DIV.
